framed_shift_register: RTL
==========================

# framed_shift_register

Parametrised successor to the lab shift register: a WIDTH-bit serial/parallel shift register with selectable shift direction (MSB-first or LSB-first), a bit counter, and a one-cycle frame-complete strobe. It sits between the SPI-style peripheral front end (which supplies the one-cycle `peripheralClkEdge` qualifier) and the parallel datapath, and it replaces the fixed 8-bit register in new designs.

## Interface
Parameters:
- `WIDTH`, default 8: register width in bits; legal values are 2 and above.
- `RESET_VALUE`, default `{WIDTH{1'b0}}`: register contents after reset.
- Derived localparam `CNTW` = `$clog2(WIDTH+1)`: bit-counter width.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `resetN`  in  1  synchronous, active-low reset.
- `peripheralClkEdge`  in  1  one-cycle shift qualifier in the `clk` domain.
- `parallelLoad`  in  1  load `parallelDataIn` on the next edge.
- `parallelDataIn`  in  WIDTH  parallel load data.
- `serialDataIn`  in  1  bit shifted in on each qualified edge.
- `msbFirst`  in  1  direction select; 1 = shift left, 0 = shift right.
- `parallelDataOut`  out  WIDTH  current register contents.
- `serialDataOut`  out  1  outgoing bit: `reg[WIDTH-1]` when `msbFirst`=1, `reg[0]` when `msbFirst`=0.
- `bitCount`  out  CNTW  shifts completed in the current frame, 0..WIDTH-1.
- `frameDone`  out  1  registered one-cycle pulse after the WIDTH-th shift.

## Operation
Priority at each rising `clk`, highest first:
- `resetN`=0:
  - reg <= RESET_VALUE; `bitCount` <= 0; `frameDone` <= 0.
  - All other inputs are ignored.
- `parallelLoad`=1:
  - reg <= `parallelDataIn`; `bitCount` <= 0; `frameDone` <= 0.
  - Any simultaneous `peripheralClkEdge` is discarded.
- `peripheralClkEdge`=1, shift:
  - `msbFirst`=1: reg <= {reg[WIDTH-2:0], `serialDataIn`}.
  - `msbFirst`=0: reg <= {`serialDataIn`, reg[WIDTH-1:1]}.
  - If `bitCount`==WIDTH-1: `bitCount` <= 0 and `frameDone` <= 1.
  - Otherwise: `bitCount` <= `bitCount`+1 and `frameDone` <= 0.
- Otherwise, hold: reg and `bitCount` keep their values; `frameDone` <= 0.

Outputs and boundary conditions:
- `parallelDataOut` is the register itself.
- `serialDataOut` is a combinational mux of the register and `msbFirst`.
- Changing `msbFirst` mid-frame takes effect immediately on `serialDataOut` and on the next shift. It does not reset `bitCount`.
- `bitCount` wraps from WIDTH-1 to 0 with no gap. Back-to-back frames produce one `frameDone` every WIDTH qualified edges.
- `peripheralClkEdge` held high for N cycles produces N shifts. The block does no edge detection.

## Timing
- Reset values: `parallelDataOut`=RESET_VALUE, `serialDataOut`=the selected bit of RESET_VALUE, `bitCount`=0, `frameDone`=0.
- Load latency is 1 cycle: data is visible on `parallelDataOut` and `serialDataOut` after the loading edge.
- Shift latency is 1 cycle per qualified edge.
- `frameDone` is high for exactly the one cycle following the edge that performed the WIDTH-th shift.
- If reset is asserted mid-frame, the frame is abandoned. The next `frameDone` requires WIDTH fresh shifts after reset deasserts.
- If a load occurs mid-frame, the frame likewise restarts with `bitCount`=0.
- No combinational path exists from any input to `parallelDataOut`, `bitCount`, or `frameDone`.

## Test plan
- Reset: hold `resetN`=0 for 2 cycles with `parallelLoad`=1 and `parallelDataIn`=8'hFF -> `parallelDataOut`=8'h00, `bitCount`=0, `frameDone`=0.
- MSB-first legacy check (WIDTH=8):
  - Load 8'b10101010 with `msbFirst`=1 -> `serialDataOut`=1.
  - One edge with `serialDataIn`=1 -> 8'b01010101, `serialDataOut`=0.
  - A second edge -> 8'b10101011, `serialDataOut`=1.
  - Idle 2 cycles -> values unchanged.
- LSB-first: load 8'hAA with `msbFirst`=0 -> `serialDataOut`=0; one edge with `serialDataIn`=1 -> 8'hD5, `serialDataOut`=1, `bitCount`=1.
- Frame strobe:
  - 7 edges -> `bitCount`=7 and no `frameDone`.
  - The 8th edge -> `bitCount`=0 and `frameDone`=1 for exactly one cycle.
  - 8 further back-to-back edges -> a second single pulse.
- Collision: `parallelLoad`=1 and `peripheralClkEdge`=1 in the same cycle with `parallelDataIn`=8'h3C -> `parallelDataOut`=8'h3C, `bitCount`=0.
- Reset mid-frame:
  - After 3 edges, pulse `resetN`=0 for one cycle -> `bitCount`=0.
  - `frameDone` then fires only after the 8th post-reset edge.
  - Repeat with a WIDTH=4 instance: the pulse comes after 4 edges.

Source files
------------

// File: rtl/framed_shift_register.sv
// WIDTH-bit serial/parallel shift register with selectable shift direction,
// a per-frame bit counter and a one-cycle frame-complete strobe.
module framed_shift_register #(
    parameter int unsigned     WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    localparam int unsigned    CNTW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             peripheralClkEdge,
    input  logic             parallelLoad,
    input  logic [WIDTH-1:0] parallelDataIn,
    input  logic             serialDataIn,
    input  logic             msbFirst,
    output logic [WIDTH-1:0] parallelDataOut,
    output logic             serialDataOut,
    output logic [CNTW-1:0]  bitCount,
    output logic             frameDone
);

    localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNTW-1:0]  cnt_q,   cnt_d;
    logic             done_q,  done_d;

    // Next-state: load beats shift; the strobe is only raised by the frame-closing shift.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (parallelLoad) begin
            shreg_d = parallelDataIn;
            cnt_d   = '0;
        end else if (peripheralClkEdge) begin
            if (msbFirst) begin
                shreg_d = {shreg_q[WIDTH-2:0], serialDataIn};
            end else begin
                shreg_d = {serialDataIn, shreg_q[WIDTH-1:1]};
            end
            if (cnt_q == LAST_BIT) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            shreg_q <= RESET_VALUE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Outgoing bit follows msbFirst immediately, even mid-frame.
    always_comb begin
        serialDataOut = msbFirst ? shreg_q[WIDTH-1] : shreg_q[0];
    end

    assign parallelDataOut = shreg_q;
    assign bitCount        = cnt_q;
    assign frameDone       = done_q;

endmodule
